// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the 24-bit DAC SPI transmitter.
package dac_spi_pkg;

  localparam int DAC_FRAME_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } dac_spi_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dac_spi_if.sv
// Controller-to-DAC-transmitter channel: write handshake plus the SPI pins.
interface dac_spi_if;
  import dac_spi_pkg::*;

  logic [DAC_FRAME_W-1:0] dat;
  logic                   wre;
  logic                   rdy;
  logic                   done;
  logic                   sclk;
  logic                   mosi;
  logic                   cs_n;

  modport master (output dat, wre, input rdy, done);
  modport slave  (input dat, wre, output rdy, done, sclk, mosi, cs_n);
endinterface

// File: rtl/dac_spi_tx.sv
// SPI transmitter for 24-bit DAC threshold frames: MSB first, data stable on SCLK fall.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [DAC_FRAME_W-1:0] dat_i,
  input  logic                   wre_i,
  output logic                   rdy_o,
  output logic                   done_o,
  output logic                   sclk_o,
  output logic                   mosi_o,
  output logic                   cs_n_o
);

  localparam int PH_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP)) + 1;

  localparam logic [PH_W-1:0] DIV_LD   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] SETUP_LD = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] HOLD_LD  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0] GAP_LD   = PH_W'(CS_GAP - 1);
  localparam logic [4:0]      BIT_TOP  = 5'(DAC_FRAME_W - 1);

  dac_spi_state_t         state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [4:0]             bit_q, bit_d;
  logic [DAC_FRAME_W-1:0] sreg_q, sreg_d;
  logic                   sclk_q, sclk_d;
  logic                   cs_n_q, cs_n_d;
  logic                   done_q, done_d;
  logic                   rdy_q, rdy_d;

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  // Outputs are computed for the next state and registered alongside it, so
  // every pin comes straight from a flop; mosi is the shift register MSB.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    rdy_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (rdy_q && wre_i) begin
          state_d = SETUP;
          phase_d = SETUP_LD;
          sreg_d  = dat_i;
          cs_n_d  = 1'b0;
        end else begin
          rdy_d = 1'b1;
        end
      end
      SETUP: begin
        if (phase_q != '0) begin
          phase_d = phase_q - PH_W'(1);
        end else begin
          state_d = SHIFT;
          phase_d = DIV_LD;
          bit_d   = BIT_TOP;
          sclk_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (phase_q != '0) begin
          phase_d = phase_q - PH_W'(1);
        end else if (sclk_q) begin
          sclk_d  = 1'b0;
          phase_d = DIV_LD;
        end else if (bit_q == '0) begin
          state_d = HOLD;
          phase_d = HOLD_LD;
        end else begin
          // Next bit goes out together with the rising edge.
          bit_d   = bit_q - 5'd1;
          sclk_d  = 1'b1;
          phase_d = DIV_LD;
          sreg_d  = {sreg_q[DAC_FRAME_W-2:0], 1'b0};
        end
      end
      HOLD: begin
        if (phase_q != '0) begin
          phase_d = phase_q - PH_W'(1);
        end else begin
          state_d = GAP;
          phase_d = GAP_LD;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (phase_q != '0) begin
          phase_d = phase_q - PH_W'(1);
        end else begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rdy_o  = rdy_q;
  assign done_o = done_q;
  assign sclk_o = sclk_q;
  assign mosi_o = sreg_q[DAC_FRAME_W-1];
  assign cs_n_o = cs_n_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench: ch0 uses default timing, ch1 the minimum timing (all 1).
module tb_dac_spi_tx;
  import dac_spi_pkg::*;

  typedef struct {
    logic [23:0] data;
    int          cs_low;
    int          rdy_low;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_a [2];
  logic [23:0] dat_a  [2];
  logic        wre_a  [2];

  dac_spi_if if0 ();
  dac_spi_if if1 ();

  assign if0.dat = dat_a[0];
  assign if0.wre = wre_a[0];
  assign if1.dat = dat_a[1];
  assign if1.wre = wre_a[1];

  dac_spi_tx #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) dut0 (
    .clk_i (clk),      .arst_i(arst_a[0]), .dat_i (if0.dat), .wre_i (if0.wre),
    .rdy_o (if0.rdy),  .done_o(if0.done),  .sclk_o(if0.sclk), .mosi_o(if0.mosi),
    .cs_n_o(if0.cs_n)
  );

  dac_spi_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut1 (
    .clk_i (clk),      .arst_i(arst_a[1]), .dat_i (if1.dat), .wre_i (if1.wre),
    .rdy_o (if1.rdy),  .done_o(if1.done),  .sclk_o(if1.sclk), .mosi_o(if1.mosi),
    .cs_n_o(if1.cs_n)
  );

  logic rdy_a [2], done_a [2], sclk_a [2], mosi_a [2], cs_a [2];
  assign rdy_a[0]  = if0.rdy;  assign rdy_a[1]  = if1.rdy;
  assign done_a[0] = if0.done; assign done_a[1] = if1.done;
  assign sclk_a[0] = if0.sclk; assign sclk_a[1] = if1.sclk;
  assign mosi_a[0] = if0.mosi; assign mosi_a[1] = if1.mosi;
  assign cs_a[0]   = if0.cs_n; assign cs_a[1]   = if1.cs_n;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int tests = 0;
  int fails = 0;
  int n_timeouts = 0;
  logic end_req = 1'b0;
  logic mon_done = 1'b0;

  task automatic push_exp(input int ch, input logic [23:0] d, input int csl,
                          input int rl, input int gap);
    exp_t e;
    e.data = d; e.cs_low = csl; e.rdy_low = rl; e.gap = gap;
    if (ch == 0) exp_q0.push_back(e);
    else         exp_q1.push_back(e);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input int ch, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s ch%0d: got 0x%0h expected 0x%0h", name, ch, act, expv);
    end
  endtask

  int cd [2] = '{2, 1};

  initial begin
    logic        cs_p [2], sclk_p [2], mosi_p [2], rdy_p [2], rst_p1 [2], rst_p2 [2];
    logic [23:0] shreg [2];
    int          nfall [2], nrise [2], cslow [2], rdylow [2], hilen [2], lasthi [2];
    int          lastchg [2], lastfall [2];
    logic        have_cur [2];
    exp_t        cur [2];
    int          cyc;
    logic        cs_rise;
    exp_t        e;
    logic        got;
    cyc = 0;
    for (int c = 0; c < 2; c++) begin
      cs_p[c] = 1'b1; sclk_p[c] = 1'b0; mosi_p[c] = 1'b0; rdy_p[c] = 1'b0;
      rst_p1[c] = 1'b0; rst_p2[c] = 1'b0; shreg[c] = '0;
      nfall[c] = 0; nrise[c] = 0; cslow[c] = 0; rdylow[c] = 0; hilen[c] = 0;
      lasthi[c] = 0; lastchg[c] = -1000; lastfall[c] = -1000; have_cur[c] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int ch = 0; ch < 2; ch++) begin
        if (rst_p1[ch]) begin
          chk("rst_cs_n", ch, int'(cs_a[ch]), 1);
          chk("rst_sclk", ch, int'(sclk_a[ch]), 0);
          chk("rst_done", ch, int'(done_a[ch]), 0);
          chk("rst_rdy", ch, int'(rdy_a[ch]), 0);
        end else if (rst_p2[ch]) begin
          chk("rdy_after_rst", ch, int'(rdy_a[ch]), 1);
        end

        if (cs_a[ch]) chk("sclk_idle_when_cs_high", ch, int'(sclk_a[ch]), 0);

        cs_rise = !cs_p[ch] && cs_a[ch];
        chk("done_pulse", ch, int'(done_a[ch]), int'(cs_rise && !rst_p1[ch]));

        if (cs_p[ch] && !cs_a[ch]) begin
          lasthi[ch] = hilen[ch];
          hilen[ch] = 0; cslow[ch] = 0; nfall[ch] = 0; nrise[ch] = 0; shreg[ch] = '0;
        end
        if (cs_a[ch]) hilen[ch]++;
        else          cslow[ch]++;

        if (!cs_a[ch] && !cs_p[ch]) begin
          if (mosi_a[ch] != mosi_p[ch]) begin
            chk("mosi_vs_prev_fall", ch, int'((cyc - lastfall[ch]) >= cd[ch]), 1);
            lastchg[ch] = cyc;
          end
          if (!sclk_p[ch] && sclk_a[ch]) nrise[ch]++;
          if (sclk_p[ch] && !sclk_a[ch]) begin
            chk("mosi_vs_next_fall", ch, int'((cyc - lastchg[ch]) >= cd[ch]), 1);
            lastfall[ch] = cyc;
            shreg[ch] = {shreg[ch][22:0], mosi_a[ch]};
            nfall[ch]++;
          end
        end

        if (cs_rise && !rst_p1[ch]) begin
          got = 1'b0;
          if (ch == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); got = 1'b1; end
          if (ch == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); got = 1'b1; end
          if (!got) begin
            chk("unexpected_frame", ch, 1, 0);
          end else begin
            chk("frame_data", ch, int'(shreg[ch]), int'(e.data));
            chk("sclk_falls", ch, nfall[ch], 24);
            chk("sclk_rises", ch, nrise[ch], 24);
            chk("cs_low_cycles", ch, cslow[ch], e.cs_low);
            if (e.gap >= 0) chk("cs_high_between", ch, lasthi[ch], e.gap);
            cur[ch] = e;
            have_cur[ch] = 1'b1;
          end
        end

        if (!rdy_a[ch]) rdylow[ch]++;
        if (!rdy_p[ch] && rdy_a[ch]) begin
          if (have_cur[ch]) chk("rdy_low_cycles", ch, rdylow[ch], cur[ch].rdy_low);
          have_cur[ch] = 1'b0;
        end
        if (rdy_a[ch]) rdylow[ch] = 0;

        rst_p2[ch] = rst_p1[ch];
        rst_p1[ch] = arst_a[ch];
        cs_p[ch] = cs_a[ch]; sclk_p[ch] = sclk_a[ch];
        mosi_p[ch] = mosi_a[ch]; rdy_p[ch] = rdy_a[ch];
      end

      if (end_req && !mon_done) begin
        chk("pending_frames", 0, exp_q0.size(), 0);
        chk("pending_frames", 1, exp_q1.size(), 0);
        chk("wait_timeouts", 0, n_timeouts, 0);
        mon_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_rdy(input int ch);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (rdy_a[ch]) return;
    end
    n_timeouts++;
  endtask

  task automatic send(input int ch, input logic [23:0] d);
    wait_rdy(ch);
    dat_a[ch] = d;
    wre_a[ch] = 1'b1;
    @(posedge clk); #1;
    wre_a[ch] = 1'b0;
  endtask

  initial begin
    arst_a[0] = 1'b1; arst_a[1] = 1'b1;
    wre_a[0] = 1'b0;  wre_a[1] = 1'b0;
    dat_a[0] = '0;    dat_a[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    arst_a[0] = 1'b0; arst_a[1] = 1'b0;

    // Minimum-timing channel: 1+48+1 cycles select low, 51 not ready.
    push_exp(1, 24'h5A5A5A, 50, 51, -1);
    send(1, 24'h5A5A5A);

    push_exp(0, 24'hA5C3F0, 100, 104, -1);
    send(0, 24'hA5C3F0);

    // wre held high across two frames: 4 GAP + 1 IDLE cycles of select high.
    wait_rdy(0);
    push_exp(0, 24'h000001, 100, 104, -1);
    push_exp(0, 24'hFFFFFF, 100, 104, 5);
    dat_a[0] = 24'h000001;
    wre_a[0] = 1'b1;
    @(posedge clk); #1;
    dat_a[0] = 24'hFFFFFF;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (rdy_a[0]) break;
    end
    @(posedge clk); #1;
    wre_a[0] = 1'b0;

    // Write attempt in the middle of a shift must be dropped.
    push_exp(0, 24'hC0FFEE, 100, 104, -1);
    send(0, 24'hC0FFEE);
    repeat (30) @(posedge clk);
    #1;
    dat_a[0] = 24'h123456;
    wre_a[0] = 1'b1;
    @(posedge clk); #1;
    wre_a[0] = 1'b0;

    // Abort around bit 10, then a clean frame.
    send(0, 24'h3C3C3C);
    repeat (53) @(posedge clk);
    #1;
    arst_a[0] = 1'b1;
    @(posedge clk); #1;
    arst_a[0] = 1'b0;
    push_exp(0, 24'h800000, 100, 104, -1);
    send(0, 24'h800000);

    wait_rdy(0);
    wait_rdy(1);
    repeat (10) @(posedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails + (mon_done ? 0 : 1));
    $finish;
  end

endmodule
